// File: rtl/hsr_danh_axi_regs.sv
// AXI4 slave front-end of the HSR DANH node: TX/RX frame buffers plus GMAC/HSR CSRs.
// Optional feature macro HSR_DANH_PROT_CHECK_EN: unprivileged CSR accesses are refused with SLVERR.
module hsr_danh_axi_regs #(
    parameter int          AXI_WIDTH_AD      = 32,
    parameter int          AXI_WIDTH_DA      = 32,
    parameter logic [31:0] ADDR_START_MEM_TX = 32'h4100_0000,
    parameter logic [31:0] ADDR_START_MEM_RX = 32'h4200_0000,
    parameter logic [31:0] ADDR_START_GMAC   = 32'h4300_0000,
    parameter int          MEM_DEPTH         = 256,
    parameter logic [47:0] MAC_ADDR_RST      = 48'hF0_12_34_56_78_00
) (
    input  logic                      s_axi_aclk,
    input  logic                      s_axi_areset,
    input  logic [AXI_WIDTH_AD-1:0]   s_axi_awaddr,
    input  logic [7:0]                s_axi_awlen,
    input  logic [2:0]                s_axi_awsize,
    input  logic [1:0]                s_axi_awburst,
    input  logic                      s_axi_awlock,
    input  logic [2:0]                s_axi_awprot,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [AXI_WIDTH_DA-1:0]   s_axi_wdata,
    input  logic [AXI_WIDTH_DA/8-1:0] s_axi_wstrb,
    input  logic                      s_axi_wlast,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic [AXI_WIDTH_AD-1:0]   s_axi_araddr,
    input  logic [7:0]                s_axi_arlen,
    input  logic [2:0]                s_axi_arsize,
    input  logic [1:0]                s_axi_arburst,
    input  logic                      s_axi_arlock,
    input  logic [2:0]                s_axi_arprot,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [AXI_WIDTH_DA-1:0]   s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rlast,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    input  logic [7:0]                board_slide_sw,
    output logic [7:0]                board_led,
    output logic [47:0]               mac_addr,
    output logic                      hsr_enable,
    output logic                      promisc
);
    localparam int AXI_WIDTH_DS = AXI_WIDTH_DA / 8;
    localparam int LSB          = $clog2(AXI_WIDTH_DS);
    localparam int IDX_W        = $clog2(MEM_DEPTH);
    localparam logic [AXI_WIDTH_AD-1:0] STEP = AXI_WIDTH_AD'(AXI_WIDTH_DS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [23:0] OFF_MAC_LO  = 24'h00;
    localparam logic [23:0] OFF_MAC_HI  = 24'h04;
    localparam logic [23:0] OFF_CTRL    = 24'h08;
    localparam logic [23:0] OFF_STATUS  = 24'h0C;
    localparam logic [23:0] OFF_SCRATCH = 24'h10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA} r_state_t;
    typedef enum logic [1:0] {RG_TX, RG_RX, RG_CSR, RG_NONE} region_t;

    function automatic region_t decode(input logic [AXI_WIDTH_AD-1:0] a);
        logic [7:0] top;
        top = a[AXI_WIDTH_AD-1 -: 8];
        if (top == ADDR_START_MEM_TX[31:24]) return RG_TX;
        if (top == ADDR_START_MEM_RX[31:24]) return RG_RX;
        if (top == ADDR_START_GMAC[31:24])   return RG_CSR;
        return RG_NONE;
    endfunction

    function automatic logic [1:0] burst_resp(input region_t rg, input logic deny, input logic err);
        if (rg == RG_NONE)  return RESP_DECERR;
        if (deny || err)    return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    function automatic logic [AXI_WIDTH_DA-1:0] merge(input logic [AXI_WIDTH_DA-1:0] old,
                                                      input logic [AXI_WIDTH_DA-1:0] d,
                                                      input logic [AXI_WIDTH_DS-1:0] s);
        logic [AXI_WIDTH_DA-1:0] m;
        m = old;
        for (int b = 0; b < AXI_WIDTH_DS; b++) begin
            if (s[b]) m[8*b +: 8] = d[8*b +: 8];
        end
        return m;
    endfunction

    logic [AXI_WIDTH_DA-1:0] tx_mem [MEM_DEPTH];
    logic [AXI_WIDTH_DA-1:0] rx_mem [MEM_DEPTH];

    logic [31:0] mac_lo;
    logic [15:0] mac_hi;
    logic [1:0]  ctrl;
    logic [31:0] scratch;

    region_t aw_region, ar_region;
    logic    aw_deny, ar_deny;

    assign aw_region = decode(s_axi_awaddr);
    assign ar_region = decode(s_axi_araddr);
`ifdef HSR_DANH_PROT_CHECK_EN
    assign aw_deny = (aw_region == RG_CSR) && !s_axi_awprot[0];
    assign ar_deny = (ar_region == RG_CSR) && !s_axi_arprot[0];
`else
    assign aw_deny = 1'b0;
    assign ar_deny = 1'b0;
`endif

    // ---------------- write channel ----------------
    w_state_t                w_state, w_next;
    logic [AXI_WIDTH_AD-1:0] w_addr;
    logic [7:0]              w_len, w_cnt;
    logic [1:0]              w_burst;
    region_t                 w_region;
    logic                    w_deny, w_err;
    logic                    w_fire, w_last_beat, wlast_bad, csr_we;
    logic [IDX_W-1:0]        w_idx;

    assign w_fire      = s_axi_wvalid && s_axi_wready;
    assign w_last_beat = (w_cnt == w_len);
    assign wlast_bad   = (s_axi_wlast != w_last_beat);
    assign w_idx       = w_addr[LSB +: IDX_W];
    assign csr_we      = w_fire && !w_deny && (w_region == RG_CSR);

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (s_axi_awvalid && s_axi_awready) w_next = W_DATA;
            W_DATA:  if (w_fire && w_last_beat)          w_next = W_RESP;
            W_RESP:  if (s_axi_bvalid && s_axi_bready)   w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            w_state       <= W_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
            w_addr        <= '0;
            w_len         <= '0;
            w_cnt         <= '0;
            w_burst       <= '0;
            w_region      <= RG_NONE;
            w_deny        <= 1'b0;
            w_err         <= 1'b0;
        end else begin
            w_state       <= w_next;
            s_axi_awready <= (w_next == W_IDLE);
            s_axi_wready  <= (w_next == W_DATA);
            s_axi_bvalid  <= (w_next == W_RESP);
            if (s_axi_awvalid && s_axi_awready) begin
                w_addr   <= s_axi_awaddr;
                w_len    <= s_axi_awlen;
                w_burst  <= s_axi_awburst;
                w_region <= aw_region;
                w_deny   <= aw_deny;
                w_cnt    <= '0;
                w_err    <= 1'b0;
            end
            if (w_fire) begin
                w_cnt <= w_cnt + 8'd1;
                if (w_burst != BURST_FIXED) w_addr <= w_addr + STEP;
                w_err <= w_err | wlast_bad;
                if (w_last_beat) s_axi_bresp <= burst_resp(w_region, w_deny, w_err | wlast_bad);
            end
        end
    end

    // Buffers are deliberately left uninitialised by reset.
    always_ff @(posedge s_axi_aclk) begin
        if (w_fire && !w_deny) begin
            for (int b = 0; b < AXI_WIDTH_DS; b++) begin
                if (s_axi_wstrb[b]) begin
                    if (w_region == RG_TX) tx_mem[w_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                    if (w_region == RG_RX) rx_mem[w_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                end
            end
        end
    end

    logic [31:0] mac_lo_new, mac_hi_new, ctrl_new, scratch_new;
    assign mac_lo_new  = merge(mac_lo, s_axi_wdata, s_axi_wstrb);
    assign mac_hi_new  = merge({16'h0, mac_hi}, s_axi_wdata, s_axi_wstrb);
    assign ctrl_new    = merge({30'h0, ctrl}, s_axi_wdata, s_axi_wstrb);
    assign scratch_new = merge(scratch, s_axi_wdata, s_axi_wstrb);

    // MAC_LO byte 0 takes the node id from the switches at reset.
    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            mac_lo  <= {MAC_ADDR_RST[31:8], board_slide_sw};
            mac_hi  <= MAC_ADDR_RST[47:32];
            ctrl    <= 2'b00;
            scratch <= '0;
        end else if (csr_we) begin
            case (w_addr[23:0])
                OFF_MAC_LO:  mac_lo  <= mac_lo_new;
                OFF_MAC_HI:  mac_hi  <= mac_hi_new[15:0];
                OFF_CTRL:    ctrl    <= ctrl_new[1:0];
                OFF_SCRATCH: scratch <= scratch_new;
                default: ;
            endcase
        end
    end

    // ---------------- read channel ----------------
    r_state_t                r_state, r_next;
    logic [AXI_WIDTH_AD-1:0] r_addr, rd_addr;
    logic [7:0]              r_len, r_cnt;
    logic [1:0]              r_burst;
    region_t                 r_region, rd_region;
    logic                    r_deny, rd_deny;
    logic                    ar_fire, r_fire;
    logic [AXI_WIDTH_DA-1:0] rd_word;

    assign ar_fire = s_axi_arvalid && s_axi_arready;
    assign r_fire  = s_axi_rvalid && s_axi_rready;

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_fire)                r_next = R_DATA;
            R_DATA:  if (r_fire && s_axi_rlast)  r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Address of the beat that will be loaded into rdata at the next edge.
    always_comb begin
        rd_addr   = r_addr;
        rd_region = r_region;
        rd_deny   = r_deny;
        if (r_state == R_IDLE) begin
            rd_addr   = s_axi_araddr;
            rd_region = ar_region;
            rd_deny   = ar_deny;
        end else if (r_burst != BURST_FIXED) begin
            rd_addr = r_addr + STEP;
        end
        rd_word = '0;
        case (rd_region)
            RG_TX: rd_word = tx_mem[rd_addr[LSB +: IDX_W]];
            RG_RX: rd_word = rx_mem[rd_addr[LSB +: IDX_W]];
            RG_CSR: begin
                if (!rd_deny) begin
                    case (rd_addr[23:0])
                        OFF_MAC_LO:  rd_word = mac_lo;
                        OFF_MAC_HI:  rd_word = {16'h0, mac_hi};
                        OFF_CTRL:    rd_word = {30'h0, ctrl};
                        OFF_STATUS:  rd_word = {16'h2018, 8'h00, board_slide_sw};
                        OFF_SCRATCH: rd_word = scratch;
                        default:     rd_word = '0;
                    endcase
                end
            end
            default: rd_word = '0;
        endcase
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= RESP_OKAY;
            s_axi_rlast   <= 1'b0;
            r_addr        <= '0;
            r_len         <= '0;
            r_cnt         <= '0;
            r_burst       <= '0;
            r_region      <= RG_NONE;
            r_deny        <= 1'b0;
        end else begin
            r_state       <= r_next;
            s_axi_arready <= (r_next == R_IDLE);
            if (ar_fire) begin
                r_addr       <= s_axi_araddr;
                r_len        <= s_axi_arlen;
                r_burst      <= s_axi_arburst;
                r_region     <= ar_region;
                r_deny       <= ar_deny;
                r_cnt        <= '0;
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= rd_word;
                s_axi_rlast  <= (s_axi_arlen == 8'd0);
                s_axi_rresp  <= burst_resp(ar_region, ar_deny, 1'b0);
            end else if (r_fire) begin
                if (s_axi_rlast) begin
                    s_axi_rvalid <= 1'b0;
                    s_axi_rlast  <= 1'b0;
                end else begin
                    r_addr      <= rd_addr;
                    r_cnt       <= r_cnt + 8'd1;
                    s_axi_rdata <= rd_word;
                    s_axi_rlast <= ((r_cnt + 8'd1) == r_len);
                end
            end
        end
    end

    assign mac_addr   = {mac_hi, mac_lo};
    assign hsr_enable = ctrl[0];
    assign promisc    = ctrl[1];
    assign board_led  = {ctrl[0], ctrl[1], 2'b00, board_slide_sw[3:0]};

    // Inputs and bits the design intentionally does not look at.
    logic unused_ok;
    assign unused_ok = ^{s_axi_awlock, s_axi_awsize, s_axi_awprot, s_axi_arlock, s_axi_arsize,
                         s_axi_arprot, w_addr[AXI_WIDTH_AD-1:24], rd_addr[AXI_WIDTH_AD-1:24],
                         mac_hi_new[31:16], ctrl_new[31:2]};
endmodule

// File: tb/tb_hsr_danh_axi_regs.sv
// Directed self-checking bench for hsr_danh_axi_regs (buffers, CSRs, bursts, error responses).
module tb_hsr_danh_axi_regs;
    localparam int TO = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] awaddr;  logic [7:0] awlen;  logic [2:0] awsize;  logic [1:0] awburst;
    logic        awlock;  logic [2:0] awprot; logic awvalid;       logic awready;
    logic [31:0] wdata;   logic [3:0] wstrb;  logic wlast;         logic wvalid;  logic wready;
    logic [1:0]  bresp;   logic bvalid;       logic bready;
    logic [31:0] araddr;  logic [7:0] arlen;  logic [2:0] arsize;  logic [1:0] arburst;
    logic        arlock;  logic [2:0] arprot; logic arvalid;       logic arready;
    logic [31:0] rdata;   logic [1:0] rresp;  logic rlast;         logic rvalid;  logic rready;
    logic [7:0]  sw;      logic [7:0] led;    logic [47:0] mac_addr;
    logic        hsr_enable, promisc;

    hsr_danh_axi_regs dut (
        .s_axi_aclk(clk), .s_axi_areset(rst),
        .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize), .s_axi_awburst(awburst),
        .s_axi_awlock(awlock), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
        .s_axi_wready(wready), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize), .s_axi_arburst(arburst),
        .s_axi_arlock(arlock), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast), .s_axi_rvalid(rvalid),
        .s_axi_rready(rready), .board_slide_sw(sw), .board_led(led), .mac_addr(mac_addr),
        .hsr_enable(hsr_enable), .promisc(promisc)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] wdata_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] rdata_q[$];
    logic [1:0]  rresp_q[$];
    logic        rlast_q[$];
    logic [1:0]  last_bresp;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input logic [2:0] prot, input logic [3:0] strb, input int wlast_at);
        int t;
        awaddr = addr; awlen = len; awburst = burst; awprot = prot; awsize = 3'd2; awvalid = 1'b1;
        t = 0;
        while (!awready && t < TO) begin @(posedge clk); #1; t++; end
        check("aw_wait_timeout", 64'(t >= TO), 64'd0);
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wdata = wdata_q.pop_front(); wstrb = strb; wlast = (i == wlast_at); wvalid = 1'b1;
            t = 0;
            while (!wready && t < TO) begin @(posedge clk); #1; t++; end
            check("w_wait_timeout", 64'(t >= TO), 64'd0);
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        t = 0;
        while (!bvalid && t < TO) begin @(posedge clk); #1; t++; end
        check("b_wait_timeout", 64'(t >= TO), 64'd0);
        last_bresp = bresp;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [2:0] prot, input logic toggle);
        int t, got, cyc;
        logic [3:0]  pat;
        logic [31:0] held;
        logic        stalled;
        pat = 4'b1001; stalled = 1'b0; held = '0;
        araddr = addr; arlen = len; arburst = burst; arprot = prot; arsize = 3'd2; arvalid = 1'b1;
        t = 0;
        while (!arready && t < TO) begin @(posedge clk); #1; t++; end
        check("ar_wait_timeout", 64'(t >= TO), 64'd0);
        @(posedge clk); #1;
        arvalid = 1'b0;
        got = 0; cyc = 0;
        while (got <= int'(len) && cyc < 4 * TO) begin
            rready = toggle ? pat[cyc % 4] : 1'b1;
            if (stalled) check("r_stable_while_stalled", rdata, held);
            if (rvalid && rready) begin
                rdata_q.push_back(rdata); rresp_q.push_back(rresp); rlast_q.push_back(rlast);
                got++;
            end
            stalled = rvalid && !rready;
            held = rdata;
            @(posedge clk); #1;
            cyc++;
        end
        rready = 1'b0;
        check("r_beat_count", 64'(got), 64'(int'(len) + 1));
        check("r_idle_after_burst", rvalid, 1'b0);
    endtask

    task automatic compare_reads(input string tag, input logic [1:0] exp_resp);
        int n;
        n = exp_q.size();
        check({tag, "_cnt"}, 64'(rdata_q.size()), 64'(n));
        for (int i = 0; i < n && rdata_q.size() > 0; i++) begin
            check({tag, "_data"}, rdata_q.pop_front(), exp_q.pop_front());
            check({tag, "_resp"}, rresp_q.pop_front(), exp_resp);
            check({tag, "_last"}, rlast_q.pop_front(), (i == n - 1));
        end
        exp_q.delete(); rdata_q.delete(); rresp_q.delete(); rlast_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        sw = 8'h03;
        awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awlock = 1'b0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arlen = '0; arsize = '0; arburst = '0; arlock = 1'b0; arprot = '0; arvalid = 1'b0;
        rready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", awready, 1'b0);
        check("rst_arready", arready, 1'b0);
        check("rst_wready", wready, 1'b0);
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_bresp_rresp", {bresp, rresp}, 4'h0);
        check("rst_mac_addr", mac_addr, 48'hF012_3456_7803);
        check("rst_ctrl", {hsr_enable, promisc}, 2'b00);
        check("rst_led", led, 8'h03);
        rst = 1'b0;
        @(posedge clk); #1;

        // MAC CSRs after reset
        axi_read(32'h4300_0000, 8'd1, 2'b01, 3'b001, 1'b0);
        exp_q.push_back(32'h3456_7803); exp_q.push_back(32'h0000_F012);
        compare_reads("mac_rst_read", 2'b00);

        // INCR len=7 into TX buffer and back
        for (int i = 0; i < 8; i++) wdata_q.push_back(32'(i));
        axi_write(32'h4100_0000, 8'd7, 2'b01, 3'b001, 4'hF, 7);
        check("tx_incr_bresp", last_bresp, 2'b00);
        axi_read(32'h4100_0000, 8'd7, 2'b01, 3'b001, 1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i));
        compare_reads("tx_incr_read", 2'b00);

        // byte strobe into RX buffer
        wdata_q.push_back(32'h0);
        axi_write(32'h4200_0010, 8'd0, 2'b01, 3'b001, 4'hF, 0);
        wdata_q.push_back(32'hAABB_CCDD);
        axi_write(32'h4200_0010, 8'd0, 2'b01, 3'b001, 4'b0010, 0);
        check("rx_strb_bresp", last_bresp, 2'b00);
        axi_read(32'h4200_0010, 8'd0, 2'b01, 3'b001, 1'b0);
        exp_q.push_back(32'h0000_CC00);
        compare_reads("rx_strb_read", 2'b00);

        // CTRL drives core outputs and LEDs; STATUS is read-only
        wdata_q.push_back(32'h3);
        axi_write(32'h4300_0008, 8'd0, 2'b01, 3'b001, 4'hF, 0);
        check("ctrl_bresp", last_bresp, 2'b00);
        check("ctrl_hsr_enable", hsr_enable, 1'b1);
        check("ctrl_promisc", promisc, 1'b1);
        check("ctrl_led", led, 8'hC3);
        wdata_q.push_back(32'hFFFF_FFFF);
        axi_write(32'h4300_000C, 8'd0, 2'b01, 3'b001, 4'hF, 0);
        check("status_wr_bresp", last_bresp, 2'b00);
        axi_read(32'h4300_0008, 8'd1, 2'b01, 3'b001, 1'b0);
        exp_q.push_back(32'h0000_0003); exp_q.push_back(32'h2018_0003);
        compare_reads("ctrl_status_read", 2'b00);

        // unmapped region
        for (int i = 0; i < 4; i++) wdata_q.push_back(32'hDEAD_0000 + 32'(i));
        axi_write(32'h4400_0000, 8'd3, 2'b01, 3'b001, 4'hF, 3);
        check("unmapped_bresp", last_bresp, 2'b11);
        axi_read(32'h4400_0000, 8'd1, 2'b01, 3'b001, 1'b0);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        compare_reads("unmapped_read", 2'b11);

        // rready toggling 1-0-0-1
        axi_read(32'h4100_0000, 8'd7, 2'b01, 3'b001, 1'b1);
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i));
        compare_reads("rready_toggle", 2'b00);

        // early wlast: burst still ends on beat count, resp SLVERR
        wdata_q.push_back(32'h1111_2222); wdata_q.push_back(32'h3333_4444);
        axi_write(32'h4300_0010, 8'd1, 2'b01, 3'b001, 4'hF, 0);
        check("early_wlast_bresp", last_bresp, 2'b10);
        axi_read(32'h4300_0010, 8'd0, 2'b01, 3'b001, 1'b0);
        exp_q.push_back(32'h1111_2222);
        compare_reads("scratch_read", 2'b00);

        // FIXED burst keeps writing the same word
        wdata_q.push_back(32'hA); wdata_q.push_back(32'hB); wdata_q.push_back(32'hC);
        axi_write(32'h4100_0020, 8'd2, 2'b00, 3'b001, 4'hF, 2);
        check("fixed_bresp", last_bresp, 2'b00);
        axi_read(32'h4100_001C, 8'd1, 2'b01, 3'b001, 1'b0);
        exp_q.push_back(32'h7); exp_q.push_back(32'hC);
        compare_reads("fixed_read", 2'b00);

        // buffer index wraps at depth
        wdata_q.push_back(32'hD0D0_D0D0); wdata_q.push_back(32'hD1D1_D1D1);
        axi_write(32'h4100_03FC, 8'd1, 2'b01, 3'b001, 4'hF, 1);
        check("wrap_bresp", last_bresp, 2'b00);
        axi_read(32'h4100_03FC, 8'd1, 2'b01, 3'b001, 1'b0);
        exp_q.push_back(32'hD0D0_D0D0); exp_q.push_back(32'hD1D1_D1D1);
        compare_reads("wrap_read", 2'b00);

        // MAC address registers
        wdata_q.push_back(32'hDEAD_BEEF);
        axi_write(32'h4300_0000, 8'd0, 2'b01, 3'b001, 4'hF, 0);
        check("mac_lo_out", mac_addr, 48'hF012_DEAD_BEEF);
        wdata_q.push_back(32'h1234_5678);
        axi_write(32'h4300_0004, 8'd0, 2'b01, 3'b001, 4'hF, 0);
        check("mac_hi_out", mac_addr, 48'h5678_DEAD_BEEF);
        axi_read(32'h4300_0004, 8'd0, 2'b01, 3'b001, 1'b0);
        exp_q.push_back(32'h0000_5678);
        compare_reads("mac_hi_read", 2'b00);

        // unprivileged CSR access
        wdata_q.push_back(32'h0000_BAD0);
        axi_write(32'h4300_0010, 8'd0, 2'b01, 3'b000, 4'hF, 0);
`ifdef HSR_DANH_PROT_CHECK_EN
        check("prot_wr_bresp", last_bresp, 2'b10);
        axi_read(32'h4300_0010, 8'd0, 2'b01, 3'b001, 1'b0);
        exp_q.push_back(32'h1111_2222);
        compare_reads("prot_scratch_kept", 2'b00);
        axi_read(32'h4300_0010, 8'd0, 2'b01, 3'b000, 1'b0);
        exp_q.push_back(32'h0);
        compare_reads("prot_rd_denied", 2'b10);
`else
        check("prot_wr_bresp", last_bresp, 2'b00);
        axi_read(32'h4300_0010, 8'd0, 2'b01, 3'b000, 1'b0);
        exp_q.push_back(32'h0000_BAD0);
        compare_reads("prot_ignored_read", 2'b00);
`endif

        // reset in the middle of a write burst
        awaddr = 32'h4300_0010; awlen = 8'd3; awburst = 2'b01; awprot = 3'b001; awvalid = 1'b1;
        begin
            int t;
            t = 0;
            while (!awready && t < TO) begin @(posedge clk); #1; t++; end
            check("mid_aw_timeout", 64'(t >= TO), 64'd0);
        end
        @(posedge clk); #1;
        awvalid = 1'b0;
        wdata = 32'h5555_5555; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_wready", wready, 1'b0);
        check("mid_rst_bvalid", bvalid, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        bready = 1'b1;
        @(posedge clk); #1;
        check("post_rst_awready", awready, 1'b1);
        check("post_rst_no_bvalid", bvalid, 1'b0);
        bready = 1'b0;
        check("post_rst_ctrl", {hsr_enable, promisc}, 2'b00);
        axi_read(32'h4300_0010, 8'd0, 2'b01, 3'b001, 1'b0);
        exp_q.push_back(32'h0);
        compare_reads("post_rst_scratch", 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
